// File: rtl/multicycle_datapath_if.sv
// Instruction- and data-memory handshake bundle for the multi-cycle core.
// The core is the master (drives requests); memory is the slave.
interface multicycle_datapath_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ack;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ack;

  modport master (
    output imem_req, imem_addr, input imem_rdata, imem_ack,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_rdata, dmem_ack
  );
  modport slave (
    input imem_req, imem_addr, output imem_rdata, imem_ack,
    input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/multicycle_datapath.sv
// Multi-cycle RV datapath: FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack
// memory handshakes. Control comes from an external decoder that watches
// Instr and flags.
module multicycle_datapath #(
  parameter int              XLEN      = 32,
  parameter int              REG_COUNT = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ResultSrc,
  input  logic [1:0]       PCSrc,
  input  logic             ALUSrc,
  input  logic             RegWrite,
  input  logic             MemAccess,
  input  logic             MemWrite,
  input  logic [2:0]       ImmSrc,
  input  logic [3:0]       ALUControl,
  output logic [31:0]      Instr,
  output logic [3:0]       flags,
  output logic [XLEN-1:0]  PC,
  multicycle_datapath_if.master mem,
  output logic [XLEN-1:0]  Result,
  output logic             retire
);
  localparam int RW = $clog2(REG_COUNT);
  localparam int SW = $clog2(XLEN);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  state_t          state;
  logic [XLEN-1:0] regs [REG_COUNT];
  logic [XLEN-1:0] a_q, b_q, alu_out, mem_data;

  logic [RW-1:0]   rs1, rs2, rd;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext, src_b, b_eff, alu_res, pc_plus4, pc_imm, u_out, pc_next;
  logic [XLEN:0]   sum_ext;
  logic            is_add, is_sub, c_res, v_res;

  assign rs1 = Instr[15 +: RW];
  assign rs2 = Instr[20 +: RW];
  assign rd  = Instr[7 +: RW];

  // Immediate generation; everything is built as 32 bits then sign-extended.
  always_comb begin
    case (ImmSrc)
      3'b000:  imm32 = {{20{Instr[31]}}, Instr[31:20]};
      3'b001:  imm32 = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      3'b010:  imm32 = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      3'b011:  imm32 = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      3'b100:  imm32 = {Instr[31:12], 12'b0};
      default: imm32 = '0;
    endcase
    imm_ext = XLEN'($signed(imm32));
  end

  // ALU; carry/overflow are only meaningful for add and sub.
  always_comb begin
    is_add  = (ALUControl == 4'd0);
    is_sub  = (ALUControl == 4'd1);
    src_b   = ALUSrc ? imm_ext : b_q;
    b_eff   = is_sub ? ~src_b : src_b;
    sum_ext = {1'b0, a_q} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};
    case (ALUControl)
      4'd0, 4'd1: alu_res = sum_ext[XLEN-1:0];
      4'd2:       alu_res = a_q & src_b;
      4'd3:       alu_res = a_q | src_b;
      4'd4:       alu_res = a_q ^ src_b;
      4'd5:       alu_res = XLEN'($signed(a_q) < $signed(src_b));
      4'd6:       alu_res = XLEN'(a_q < src_b);
      4'd7:       alu_res = a_q << src_b[SW-1:0];
      4'd8:       alu_res = a_q >> src_b[SW-1:0];
      4'd9:       alu_res = $signed(a_q) >>> src_b[SW-1:0];
      default:    alu_res = '0;
    endcase
    c_res = (is_add || is_sub) && sum_ext[XLEN];
    v_res = (is_add || is_sub) && (a_q[XLEN-1] == b_eff[XLEN-1]) &&
            (sum_ext[XLEN-1] != a_q[XLEN-1]);
  end

  // Writeback value and next-PC selection.
  always_comb begin
    pc_plus4 = PC + XLEN'(4);
    pc_imm   = PC + imm_ext;
    u_out    = Instr[5] ? imm_ext : pc_imm;
    case (ResultSrc)
      2'b00:   Result = alu_out;
      2'b01:   Result = mem_data;
      2'b10:   Result = pc_plus4;
      default: Result = u_out;
    endcase
    case (PCSrc)
      2'b01:   pc_next = pc_imm;
      2'b10:   pc_next = {alu_out[XLEN-1:1], 1'b0};
      default: pc_next = pc_plus4;
    endcase
  end

  // Handshake outputs decode from state; reset kills them combinationally so
  // a store in flight is dropped in the very cycle reset rises.
  assign mem.imem_req   = (state == S_FETCH) && !reset;
  assign mem.imem_addr  = PC;
  assign mem.dmem_req   = (state == S_MEM) && !reset;
  assign mem.dmem_we    = mem.dmem_req && MemWrite;
  assign mem.dmem_addr  = alu_out;
  assign mem.dmem_wdata = b_q;
  assign retire         = (state == S_WB) && !reset;

  // Sequencer plus all architectural and pipeline state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      PC       <= RESET_PC;
      Instr    <= '0;
      flags    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_out  <= '0;
      mem_data <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem.imem_ack) begin
          Instr <= mem.imem_rdata;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a_q   <= (rs1 == '0) ? '0 : regs[rs1];
          b_q   <= (rs2 == '0) ? '0 : regs[rs2];
          state <= S_EXEC;
        end
        S_EXEC: begin
          alu_out <= alu_res;
          flags   <= {alu_res[XLEN-1], alu_res == '0, c_res, v_res};
          state   <= MemAccess ? S_MEM : S_WB;
        end
        S_MEM: if (mem.dmem_ack) begin
          if (!MemWrite) mem_data <= mem.dmem_rdata;
          state <= S_WB;
        end
        S_WB: begin
          if (RegWrite && rd != '0) regs[rd] <= Result;
          PC    <= pc_next;
          state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: small RV32I decoder model drives the control
// inputs, a memory responder inserts wait states, and a scoreboard queue holds
// expected writeback values from fetch until retire.
module tb_multicycle_datapath;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ResultSrc, PCSrc;
  logic        ALUSrc, RegWrite, MemAccess, MemWrite;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [31:0] Instr;
  logic [3:0]  flags;
  logic [31:0] PC, Result;
  logic        retire;

  multicycle_datapath_if #(.XLEN(32)) mif ();

  multicycle_datapath #(.XLEN(32), .REG_COUNT(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset), .ResultSrc(ResultSrc), .PCSrc(PCSrc),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemAccess(MemAccess),
    .MemWrite(MemWrite), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .Instr(Instr), .flags(flags), .PC(PC), .mem(mif), .Result(Result),
    .retire(retire)
  );

  always #5 clk = ~clk;

  // Decoder model: depends only on Instr and flags.
  always_comb begin
    ResultSrc = 2'b00; PCSrc = 2'b00; ALUSrc = 1'b0; RegWrite = 1'b0;
    MemAccess = 1'b0; MemWrite = 1'b0; ImmSrc = 3'b000; ALUControl = 4'd0;
    case (Instr[6:0])
      7'h13: begin ALUSrc = 1'b1; RegWrite = 1'b1; end
      7'h33: begin
        RegWrite = 1'b1;
        case (Instr[14:12])
          3'd0: ALUControl = Instr[30] ? 4'd1 : 4'd0;
          3'd1: ALUControl = 4'd7;
          3'd2: ALUControl = 4'd5;
          3'd3: ALUControl = 4'd6;
          3'd4: ALUControl = 4'd4;
          3'd5: ALUControl = Instr[30] ? 4'd9 : 4'd8;
          3'd6: ALUControl = 4'd3;
          default: ALUControl = 4'd2;
        endcase
      end
      7'h03: begin ALUSrc = 1'b1; MemAccess = 1'b1; ResultSrc = 2'b01; RegWrite = 1'b1; end
      7'h23: begin ALUSrc = 1'b1; ImmSrc = 3'b001; MemAccess = 1'b1; MemWrite = 1'b1; end
      7'h63: begin ALUControl = 4'd1; ImmSrc = 3'b010; PCSrc = flags[2] ? 2'b01 : 2'b00; end
      7'h37, 7'h17: begin ImmSrc = 3'b100; ResultSrc = 2'b11; RegWrite = 1'b1; end
      7'h6F: begin ImmSrc = 3'b011; ResultSrc = 2'b10; PCSrc = 2'b01; RegWrite = 1'b1; end
      7'h67: begin ALUSrc = 1'b1; ResultSrc = 2'b10; PCSrc = 2'b10; RegWrite = 1'b1; end
      default: ;
    endcase
  end

  typedef struct {
    logic [31:0] instr;
    int          iwait;
    int          dwait;
    logic [31:0] drdata;
    logic [31:0] exp_res;
    logic [31:0] exp_pc;
    int          exp_cyc;
    logic [3:0]  exp_flags;
    bit          chk_flags;
    logic [31:0] exp_daddr;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] res;
    logic [3:0]  fl;
    bit          chk;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic [31:0] instr, input int iw, input int dw,
                                  input logic [31:0] drd, input logic [31:0] res,
                                  input logic [31:0] pc, input int cyc,
                                  input logic [3:0] fl, input bit cf, input logic [31:0] da);
    vec_t v;
    v.instr = instr; v.iwait = iw; v.dwait = dw; v.drdata = drd; v.exp_res = res;
    v.exp_pc = pc; v.exp_cyc = cyc; v.exp_flags = fl; v.chk_flags = cf; v.exp_daddr = da;
    vecs.push_back(v);
  endfunction

  // Runs one instruction from FETCH through WB, acting as both memories.
  task automatic run_instr(input vec_t v, input string tag);
    int   cyc = 0, iw = 0, dw = 0, memc = 0;
    bit   done = 0;
    exp_t e, x;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0; mif.dmem_rdata = '0;
      if (mif.imem_req) begin
        mif.imem_rdata = v.instr;
        if (iw == v.iwait) begin
          mif.imem_ack = 1'b1;
          x.instr = v.instr; x.res = v.exp_res; x.fl = v.exp_flags; x.chk = v.chk_flags;
          sb.push_back(x);
        end else iw++;
      end
      if (mif.dmem_req) begin
        memc++;
        chk({tag, " dmem_addr"}, mif.dmem_addr, v.exp_daddr);
        chk({tag, " dmem_we"}, mif.dmem_we, 1'b0);
        if (dw == v.dwait) begin
          mif.dmem_ack = 1'b1; mif.dmem_rdata = v.drdata;
        end else dw++;
      end
      if (retire) begin
        done = 1;
        if (sb.size() == 0) begin
          chk({tag, " retire without fetch"}, 1, 0);
        end else begin
          e = sb.pop_front();
          chk({tag, " Result"}, Result, e.res);
          chk({tag, " Instr"}, Instr, e.instr);
          if (e.chk) chk({tag, " flags"}, flags, e.fl);
        end
      end
    end
    if (!done) chk({tag, " retire timeout"}, 0, 1);
    chk({tag, " cycles"}, cyc, v.exp_cyc);
    if (v.dwait >= 0) chk({tag, " mem cycles"}, memc, v.dwait + 1);
    @(posedge clk); #1;
    chk({tag, " next PC"}, PC, v.exp_pc);
    chk({tag, " retire pulse"}, retire, 1'b0);
  endtask

  initial begin
    int n;
    vec_t v;
    reset = 1'b1;
    mif.imem_ack = 1'b0; mif.imem_rdata = '0; mif.dmem_ack = 1'b0; mif.dmem_rdata = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset imem_req", mif.imem_req, 1'b0);
    chk("reset dmem_req", mif.dmem_req, 1'b0);
    chk("reset retire", retire, 1'b0);
    chk("reset PC", PC, 32'h100);
    @(negedge clk); reset = 1'b0; #1;
    chk("post-reset imem_req", mif.imem_req, 1'b1);
    chk("post-reset imem_addr", mif.imem_addr, 32'h100);
    chk("post-reset Instr", Instr, 32'h0);
    chk("post-reset flags", flags, 4'h0);

    //       instr         iw dw  drdata        result        nextPC      cyc flags  chk daddr
    add_vec(32'h00500093, 0, -1, 0,            32'h5,        32'h104,    4, 4'b0000, 1, 0); // addi x1,x0,5
    add_vec(32'hFFD00113, 0, -1, 0,            32'hFFFFFFFD, 32'h108,    4, 4'b1000, 1, 0); // addi x2,x0,-3
    add_vec(32'h002081B3, 0, -1, 0,            32'h2,        32'h10C,    4, 4'b0010, 1, 0); // add x3,x1,x2
    add_vec(32'h40208233, 0, -1, 0,            32'h8,        32'h110,    4, 4'b0000, 1, 0); // sub x4,x1,x2
    add_vec(32'h001122B3, 0, -1, 0,            32'h1,        32'h114,    4, 4'b0000, 1, 0); // slt x5,x2,x1
    add_vec(32'h00113333, 0, -1, 0,            32'h0,        32'h118,    4, 4'b0100, 1, 0); // sltu x6,x2,x1
    add_vec(32'h401153B3, 0, -1, 0,            32'hFFFFFFFF, 32'h11C,    4, 4'b1000, 1, 0); // sra x7,x2,x1
    add_vec(32'h00115433, 0, -1, 0,            32'h07FFFFFF, 32'h120,    4, 4'b0000, 1, 0); // srl x8,x2,x1
    add_vec(32'h0020C4B3, 0, -1, 0,            32'hFFFFFFF8, 32'h124,    4, 4'b1000, 1, 0); // xor x9,x1,x2
    add_vec(32'h12345537, 0, -1, 0,            32'h12345000, 32'h128,    4, 4'b0000, 0, 0); // lui x10
    add_vec(32'h00001597, 0, -1, 0,            32'h00001128, 32'h12C,    4, 4'b0000, 0, 0); // auipc x11,1
    add_vec(32'h00700013, 0, -1, 0,            32'h7,        32'h130,    4, 4'b0000, 1, 0); // addi x0,x0,7
    add_vec(32'h00000633, 0, -1, 0,            32'h0,        32'h134,    4, 4'b0100, 1, 0); // add x12,x0,x0
    add_vec(32'h0040A683, 0,  3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h138,    8, 4'b0000, 1, 32'h9); // lw x13,4(x1)
    add_vec(32'h00068733, 0, -1, 0,            32'hDEADBEEF, 32'h13C,    4, 4'b1000, 1, 0); // add x14,x13,x0
    add_vec(32'h0C4007EF, 2, -1, 0,            32'h140,      32'h200,    6, 4'b0000, 0, 0); // jal x15,+0xC4
    add_vec(32'hFE208CE3, 0, -1, 0,            32'h8,        32'h204,    4, 4'b0000, 1, 0); // beq x1,x2,-8
    add_vec(32'h20100067, 0, -1, 0,            32'h208,      32'h200,    4, 4'b0000, 1, 0); // jalr x0,0x201(x0)
    add_vec(32'hFE108CE3, 0, -1, 0,            32'h0,        32'h1F8,    4, 4'b0110, 1, 0); // beq x1,x1,-8

    for (int i = 0; i < vecs.size(); i++) run_instr(vecs[i], $sformatf("vec%0d", i));

    // Store at 0x1F8 interrupted by reset while waiting for dmem_ack.
    @(negedge clk);
    chk("sw fetch req", mif.imem_req, 1'b1);
    mif.imem_ack = 1'b1; mif.imem_rdata = 32'h00E0A423; // sw x14,8(x1)
    n = 0;
    do begin
      @(negedge clk); mif.imem_ack = 1'b0; n++;
    end while (!mif.dmem_req && n < 10);
    chk("sw dmem_req", mif.dmem_req, 1'b1);
    chk("sw dmem_we", mif.dmem_we, 1'b1);
    chk("sw dmem_addr", mif.dmem_addr, 32'd13);
    chk("sw dmem_wdata", mif.dmem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("sw wait req", mif.dmem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("abort dmem_req", mif.dmem_req, 1'b0);
    chk("abort retire", retire, 1'b0);
    chk("abort PC", PC, 32'h100);
    mif.dmem_ack = 1'b1;
    @(negedge clk);
    mif.dmem_ack = 1'b0; reset = 1'b0;
    #1;
    chk("abort imem_req", mif.imem_req, 1'b1);
    chk("abort imem_addr", mif.imem_addr, 32'h100);
    chk("abort Instr", Instr, 32'h0);
    chk("abort flags", flags, 4'h0);
    chk("abort dmem_req idle", mif.dmem_req, 1'b0);

    // x1 must read back 0 after reset.
    v.instr = 32'h00008633; v.iwait = 0; v.dwait = -1; v.drdata = 0; v.exp_res = 0;
    v.exp_pc = 32'h104; v.exp_cyc = 4; v.exp_flags = 4'b0100; v.chk_flags = 1; v.exp_daddr = 0;
    run_instr(v, "post-abort add");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
Parametrised multi-cycle successor to the single-cycle RV32 datapath. It keeps the external-decoder control interface and holds fetched instructions in an internal Instr register. It replaces the zero-latency instruction and data memory paths with req/ack handshakes that tolerate wait states. An internal sequencer runs each instruction through FETCH/DECODE/EXEC/MEM/WB, and XLEN and register count are generalised.

Parameters:
XLEN, 32, datapath width (32 or 64); instructions stay 32 bits.
REG_COUNT, 32, architectural registers (16 = RV32E style, 32); rd/rs indices use log2(REG_COUNT) LSBs.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
ResultSrc  in  2  00 ALUOut, 01 MemData, 10 PC+4, 11 UOut
PCSrc  in  2  00 PC+4, 01 PC+imm, 10 ALUOut with bit0 cleared, 11 PC+4
ALUSrc  in  1  0 rs2 data, 1 ImmExt
RegWrite  in  1  write rd in WB
MemAccess  in  1  instruction uses data memory
MemWrite  in  1  store when MemAccess=1
ImmSrc  in  3  000 I, 001 S, 010 B, 011 J, 100 U; others give 0
ALUControl  in  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra; others give 0
Instr  out  32  latched instruction, drives the external decoder
flags  out  4  {N,Z,C,V} registered in EXEC
PC  out  XLEN  address of the current instruction
imem_req  out  1  fetch request
imem_addr  out  XLEN  equals PC
imem_rdata  in  32  instruction word
imem_ack  in  1  fetch complete
dmem_req  out  1  data request
dmem_we  out  1  1 = store
dmem_addr  out  XLEN  equals ALUOut
dmem_wdata  out  XLEN  rs2 data latched in DECODE
dmem_rdata  in  XLEN  load data
dmem_ack  in  1  data access complete
Result  out  XLEN  writeback value (ResultSrc mux)
retire  out  1  one-cycle pulse in WB

Behaviour:
- Reset values: state=FETCH, PC=RESET_PC, Instr=0, flags=0, every register=0, ALUOut/A/B/MemData=0. Reset drops imem_req/dmem_req and retire in the same cycle it asserts.
- FETCH: imem_req=1, imem_addr=PC, held stable until imem_ack. Ack is accepted in the same cycle as req (zero-wait). On the ack edge, Instr<=imem_rdata, go to DECODE.
- DECODE, 1 cycle: A<=reg[rs1], B<=reg[rs2]. x0 always reads 0.
- EXEC, 1 cycle: ALUOut<=alu(A, ALUSrc?ImmExt:B); flags<=result flags. Next state is MEM if MemAccess, else WB.
- MEM: dmem_req=1, dmem_we=MemWrite, addr/wdata stable until dmem_ack. On the ack edge, MemData<=dmem_rdata (loads only), go to WB.
- WB, 1 cycle: if RegWrite and rd!=0, reg[rd]<=Result. PC<=PCSrc selection. retire=1. Go to FETCH.
- Control inputs must be functions of Instr and flags only. They are sampled in EXEC (ALUSrc, ALUControl, ImmSrc, MemAccess), MEM (MemWrite) and WB (all others).
- Latency: 4 cycles/instruction with zero-wait ack; 5 with a memory access. Each wait cycle adds 1.
- ImmExt is sign-extended from bit 31 to XLEN. U-type = {Instr[31:12], 12'b0}, sign-extended.
- UOut = ImmExt if Instr[5]=1 (lui), else PC+ImmExt (auipc).
- PC+4 and PC+imm are modulo 2^XLEN and wrap silently.
- Shifts use the low log2(XLEN) bits of SrcB. slt is signed, sltu unsigned.
- Flags: N=result MSB, Z=result==0. C/V come from add/sub only (C = carry out, or no-borrow for sub); both are 0 for other ops.
- Acks without an outstanding req are ignored. imem_ack outside FETCH and dmem_ack outside MEM have no effect.
- No byte enables: data accesses are full XLEN words. Addresses pass through unaligned.
- Reset mid-MEM: the store is abandoned, dmem_req falls asynchronously, and no register or PC update occurs.

Test Plan:
1. Reset with RESET_PC=0x100, release -> imem_req=1, imem_addr=0x100; all regs read 0.
2. addi x1,x0,5 (0x00500093), zero-wait ack -> retire 4 cycles after the req cycle; Result=5; x1=5; PC=0x104.
3. Load with dmem_ack delayed 3 cycles, dmem_rdata=0xDEADBEEF -> dmem_addr, dmem_we=0 stable for 4 cycles; rd=0xDEADBEEF; total 8 cycles.
4. beq with A==B, imm=-8, PC=0x200 -> flags Z=1 in WB; PCSrc=01 gives PC=0x1F8. With A!=B, PC=0x204.
5. addi x0,x0,7 -> retire pulses; x0 still reads 0.
6. Assert reset during MEM of a store -> dmem_req=0 that cycle; PC=RESET_PC; state FETCH; memory-side write not acknowledged by the core.
